// File: rtl/link_egress_buffer_if.sv
// Router-to-link egress bundle: the router push side, the link valid/ack side
// and the status outputs of one egress buffer.
interface link_egress_buffer_if #(
  parameter int unsigned FLIT_WIDTH = 40,
  parameter int unsigned CNT_WIDTH  = 16
);
  // Router side
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  in_write;
  logic                  buffer_ready;
  // Link side
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_valid;
  logic                  out_ack;
  logic                  out_sop;
  logic                  out_eop;
  // Status
  logic                  overflow_err;
  logic                  framing_err;
  logic [CNT_WIDTH-1:0]  pkt_count;

  // Driver of flits and acks (router model / testbench)
  modport master (
    output in_flit, in_write, out_ack,
    input  buffer_ready, out_flit, out_valid, out_sop, out_eop,
           overflow_err, framing_err, pkt_count
  );

  // The egress buffer itself
  modport slave (
    input  in_flit, in_write, out_ack,
    output buffer_ready, out_flit, out_valid, out_sop, out_eop,
           overflow_err, framing_err, pkt_count
  );
endinterface

// File: rtl/link_egress_buffer.sv
// Per-link egress stage: buffers router flits in a FIFO, returns packet-level
// back-pressure, and drains flits onto the link through a registered
// valid/ack stage while tracking packet framing and counting packets.
module link_egress_buffer #(
  parameter int unsigned FLIT_WIDTH = 40,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PKT_FLITS  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  link_egress_buffer_if.slave  bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned IdxW   = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int unsigned SopBit = FLIT_WIDTH - 1;

  localparam logic [CntW-1:0] Full     = CntW'(DEPTH);
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - PKT_FLITS);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PKT_FLITS - 1);
  localparam logic [IdxW-1:0] FirstIdx = IdxW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StBody
  } state_e;

  // FIFO storage and bookkeeping
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic [CntW-1:0]       w_count_next;

  // Output stage
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic                  r_out_valid;
  logic                  r_out_sop;
  logic                  r_out_eop;

  // Framing state
  state_e                r_state;
  state_e                w_state_next;
  logic [IdxW-1:0]       r_idx;
  logic [IdxW-1:0]       w_idx_next;

  // Status
  logic                  r_overflow_err;
  logic                  r_framing_err;
  logic [CNT_WIDTH-1:0]  r_pkt_count;

  // Datapath control
  logic                  w_full;
  logic                  w_empty;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_overflow;
  logic [FLIT_WIDTH-1:0] w_head;
  logic                  w_load;
  logic                  w_load_sop;
  logic                  w_load_eop;
  logic                  w_framing;

  // Handshake decode: the output stage takes a new head flit whenever it is
  // empty or its current flit leaves this cycle, so a full FIFO can still
  // accept a push in the same cycle as a pop.
  always_comb begin
    w_full     = (r_count == Full);
    w_empty    = (r_count == '0);
    w_xfer     = r_out_valid & bus.out_ack;
    w_pop      = ~w_empty & (~r_out_valid | bus.out_ack);
    w_push     = bus.in_write & (~w_full | w_pop);
    w_overflow = bus.in_write & w_full & ~w_pop;
    w_head     = r_mem[r_rd_ptr];
  end

  // Occupancy next-state
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage write (no reset: contents are qualified by the pointers)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_flit;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Framing FSM: decides for each popped flit whether it is loaded, with what
  // sop/eop marking, or discarded as an orphan payload.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_load_sop   = 1'b0;
    w_load_eop   = 1'b0;
    w_framing    = 1'b0;
    if (w_pop) begin
      unique case (r_state)
        StIdle: begin
          if (w_head[SopBit]) begin
            w_load       = 1'b1;
            w_load_sop   = 1'b1;
            w_idx_next   = FirstIdx;
            w_state_next = StBody;
          end else begin
            // Payload with no header in front of it: drop it
            w_framing = 1'b1;
          end
        end
        StBody: begin
          if (w_head[SopBit]) begin
            // Early header truncates the current packet; restart on it
            w_framing  = 1'b1;
            w_load     = 1'b1;
            w_load_sop = 1'b1;
            w_idx_next = FirstIdx;
          end else begin
            w_load     = 1'b1;
            w_load_eop = (r_idx == LastIdx);
            if (r_idx == LastIdx) begin
              w_idx_next   = '0;
              w_state_next = StIdle;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_idx_next   = '0;
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // Framing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Output register: reload on accepted pop, otherwise hold; go idle once the
  // current flit leaves with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else if (w_load) begin
      r_out_flit  <= w_head;
      r_out_valid <= 1'b1;
      r_out_sop   <= w_load_sop;
      r_out_eop   <= w_load_eop;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky errors and completed-packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow_err <= 1'b0;
      r_framing_err  <= 1'b0;
      r_pkt_count    <= '0;
    end else begin
      r_overflow_err <= r_overflow_err | w_overflow;
      r_framing_err  <= r_framing_err | w_framing;
      if (w_xfer && r_out_eop) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
    end
  end

  // Port drive; buffer_ready advertises room for a whole packet
  always_comb begin
    bus.buffer_ready = (r_count <= ReadyMax);
    bus.out_flit     = r_out_flit;
    bus.out_valid    = r_out_valid;
    bus.out_sop      = r_out_sop;
    bus.out_eop      = r_out_eop;
    bus.overflow_err = r_overflow_err;
    bus.framing_err  = r_framing_err;
    bus.pkt_count    = r_pkt_count;
  end

endmodule

// File: tb/tb_link_egress_buffer.sv
// Directed bench for link_egress_buffer: inputs are driven and outputs sampled
// on the falling clock edge, with hand-derived expected values per step.
module tb_link_egress_buffer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [39:0] fill [10];

  localparam logic [39:0] PktH  = 40'h80_0000_0001;
  localparam logic [39:0] PktP2 = 40'h00_0000_0002;
  localparam logic [39:0] PktP3 = 40'h00_0000_0003;
  localparam logic [39:0] PktP4 = 40'h00_DEAD_BEEF;

  link_egress_buffer_if bus ();

  link_egress_buffer #(
    .FLIT_WIDTH(40),
    .DEPTH     (8),
    .PKT_FLITS (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [39:0] f,
                         input logic s, input logic e);
    chk1({tag, "_valid"}, bus.out_valid, v);
    if (v) begin
      chk({tag, "_flit"}, 64'(bus.out_flit), 64'(f));
      chk1({tag, "_sop"}, bus.out_sop, s);
      chk1({tag, "_eop"}, bus.out_eop, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_write = 1'b0;
    bus.out_ack  = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One 4-flit packet with the link always acking
  task automatic run_pkt(input string tag, input logic [15:0] exp_cnt);
    @(negedge clk);
    bus.out_ack  = 1'b1;
    bus.in_write = 1'b1;
    bus.in_flit  = PktH;
    @(negedge clk);
    chk1({tag, "_lat"}, bus.out_valid, 1'b0);
    bus.in_flit = PktP2;
    @(negedge clk);
    chk_out({tag, "_f0"}, 1'b1, PktH, 1'b1, 1'b0);
    bus.in_flit = PktP3;
    @(negedge clk);
    chk_out({tag, "_f1"}, 1'b1, PktP2, 1'b0, 1'b0);
    bus.in_flit = PktP4;
    @(negedge clk);
    chk_out({tag, "_f2"}, 1'b1, PktP3, 1'b0, 1'b0);
    bus.in_write = 1'b0;
    @(negedge clk);
    chk_out({tag, "_f3"}, 1'b1, PktP4, 1'b0, 1'b1);
    @(negedge clk);
    chk1({tag, "_idle"}, bus.out_valid, 1'b0);
    chk({tag, "_cnt"}, 64'(bus.pkt_count), 64'(exp_cnt));
    chk1({tag, "_ovf"}, bus.overflow_err, 1'b0);
    chk1({tag, "_frm"}, bus.framing_err, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 10; k++) begin
      fill[k] = 40'h00_0000_1000 | 40'(k);
      fill[k][33:32] = 2'(k);
      if (k % 4 == 0) fill[k][39] = 1'b1;
    end

    rst_n        = 1'b1;
    bus.in_write = 1'b0;
    bus.in_flit  = '0;
    bus.out_ack  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_valid", bus.out_valid, 1'b0);
    chk("rst_flit", 64'(bus.out_flit), 64'd0);
    chk1("rst_sop", bus.out_sop, 1'b0);
    chk1("rst_eop", bus.out_eop, 1'b0);
    chk1("rst_ready", bus.buffer_ready, 1'b1);
    chk1("rst_ovf", bus.overflow_err, 1'b0);
    chk1("rst_frm", bus.framing_err, 1'b0);
    chk("rst_cnt", 64'(bus.pkt_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single packet, link always ready
    run_pkt("t1", 16'd1);

    // Back-pressure: link stalls with the header on the wire
    @(negedge clk);
    bus.out_ack  = 1'b0;
    bus.in_write = 1'b1;
    bus.in_flit  = PktH;
    @(negedge clk);
    bus.in_flit = PktP2;
    @(negedge clk);
    chk_out("t2_stall0", 1'b1, PktH, 1'b1, 1'b0);
    bus.in_flit = PktP3;
    @(negedge clk);
    chk_out("t2_stall1", 1'b1, PktH, 1'b1, 1'b0);
    bus.in_flit = PktP4;
    @(negedge clk);
    chk_out("t2_stall2", 1'b1, PktH, 1'b1, 1'b0);
    bus.in_write = 1'b0;
    @(negedge clk);
    chk_out("t2_stall3", 1'b1, PktH, 1'b1, 1'b0);
    chk1("t2_ready", bus.buffer_ready, 1'b1);
    @(negedge clk);
    chk_out("t2_stall4", 1'b1, PktH, 1'b1, 1'b0);
    bus.out_ack = 1'b1;
    @(negedge clk);
    chk_out("t2_f1", 1'b1, PktP2, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("t2_f2", 1'b1, PktP3, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("t2_f3", 1'b1, PktP4, 1'b0, 1'b1);
    @(negedge clk);
    chk1("t2_idle", bus.out_valid, 1'b0);
    chk("t2_cnt", 64'(bus.pkt_count), 64'd2);
    bus.out_ack = 1'b0;

    // Fill with the link stalled; the 10th flit finds the FIFO full
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) chk1("t3_ready_c4", bus.buffer_ready, 1'b1);
      if (k == 6) chk1("t3_ready_c5", bus.buffer_ready, 1'b0);
      if (k == 9) chk1("t3_ovf_c8", bus.overflow_err, 1'b0);
      bus.in_write = 1'b1;
      bus.in_flit  = fill[k];
    end
    @(negedge clk);
    bus.in_write = 1'b0;
    chk1("t3_ovf", bus.overflow_err, 1'b1);
    chk1("t3_ready_full", bus.buffer_ready, 1'b0);
    chk_out("t3_hold", 1'b1, fill[0], 1'b1, 1'b0);
    bus.out_ack = 1'b1;
    for (int j = 1; j < 9; j++) begin
      @(negedge clk);
      chk_out($sformatf("t3_d%0d", j), 1'b1, fill[j], (j % 4 == 0), (j % 4 == 3));
    end
    @(negedge clk);
    chk1("t3_nine_only", bus.out_valid, 1'b0);
    chk("t3_cnt", 64'(bus.pkt_count), 64'd4);

    do_reset();
    chk1("r1_ovf", bus.overflow_err, 1'b0);
    chk("r1_cnt", 64'(bus.pkt_count), 64'd0);

    // Full FIFO with a push and a pop in the same cycle
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.in_write = 1'b1;
      bus.in_flit  = fill[k];
    end
    @(negedge clk);
    chk1("t4_ready_full", bus.buffer_ready, 1'b0);
    chk1("t4_ovf_pre", bus.overflow_err, 1'b0);
    bus.in_flit = 40'h00_0000_00AA;
    bus.out_ack = 1'b1;
    for (int j = 1; j < 9; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.in_write = 1'b0;
        chk1("t4_ovf_post", bus.overflow_err, 1'b0);
        chk1("t4_still_full", bus.buffer_ready, 1'b0);
      end
      chk_out($sformatf("t4_d%0d", j), 1'b1, fill[j], (j % 4 == 0), (j % 4 == 3));
    end
    @(negedge clk);
    chk_out("t4_pushed", 1'b1, 40'h00_0000_00AA, 1'b0, 1'b0);
    @(negedge clk);
    chk1("t4_idle", bus.out_valid, 1'b0);
    chk("t4_cnt", 64'(bus.pkt_count), 64'd2);
    chk1("t4_ovf_end", bus.overflow_err, 1'b0);

    do_reset();

    // Framing: orphan payload, then an early header at index 2
    @(negedge clk);
    bus.out_ack  = 1'b1;
    bus.in_write = 1'b1;
    bus.in_flit  = 40'h00_0000_0BAD;
    @(negedge clk);
    chk1("t5_frm0", bus.framing_err, 1'b0);
    bus.in_flit = 40'h80_0000_0100;
    @(negedge clk);
    chk1("t5_orphan_out", bus.out_valid, 1'b0);
    chk1("t5_frm1", bus.framing_err, 1'b1);
    bus.in_flit = 40'h00_0000_0101;
    @(negedge clk);
    chk_out("t5_h1", 1'b1, 40'h80_0000_0100, 1'b1, 1'b0);
    bus.in_flit = 40'h81_0000_0200;
    @(negedge clk);
    chk_out("t5_q1", 1'b1, 40'h00_0000_0101, 1'b0, 1'b0);
    bus.in_flit = 40'h00_0000_0201;
    @(negedge clk);
    chk_out("t5_h2", 1'b1, 40'h81_0000_0200, 1'b1, 1'b0);
    bus.in_flit = 40'h00_0000_0202;
    @(negedge clk);
    chk_out("t5_q2", 1'b1, 40'h00_0000_0201, 1'b0, 1'b0);
    bus.in_flit = 40'h00_0000_0203;
    @(negedge clk);
    chk_out("t5_q3", 1'b1, 40'h00_0000_0202, 1'b0, 1'b0);
    bus.in_write = 1'b0;
    @(negedge clk);
    chk_out("t5_q4", 1'b1, 40'h00_0000_0203, 1'b0, 1'b1);
    chk("t5_cnt_pre", 64'(bus.pkt_count), 64'd0);
    @(negedge clk);
    chk1("t5_idle", bus.out_valid, 1'b0);
    chk("t5_cnt", 64'(bus.pkt_count), 64'd1);
    chk1("t5_frm_sticky", bus.framing_err, 1'b1);

    // Asynchronous reset after two flits of a packet have gone out
    @(negedge clk);
    bus.in_write = 1'b1;
    bus.in_flit  = PktH;
    @(negedge clk);
    bus.in_flit = PktP2;
    @(negedge clk);
    chk_out("t6_f0", 1'b1, PktH, 1'b1, 1'b0);
    bus.in_flit = PktP3;
    @(negedge clk);
    chk_out("t6_f1", 1'b1, PktP2, 1'b0, 1'b0);
    bus.in_flit = PktP4;
    @(negedge clk);
    chk_out("t6_f2", 1'b1, PktP3, 1'b0, 1'b0);
    bus.in_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid", bus.out_valid, 1'b0);
    chk("t6_rst_flit", 64'(bus.out_flit), 64'd0);
    chk("t6_rst_cnt", 64'(bus.pkt_count), 64'd0);
    chk1("t6_rst_frm", bus.framing_err, 1'b0);
    chk1("t6_rst_ready", bus.buffer_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt("t6_fresh", 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000");
    $fatal(1);
  end

endmodule
